// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: frame-latched glyph codes, de-ghost blank per slot.
// Optional per-digit blinking is enabled by defining SEGDISP_BLINK_EN (adds the blink_mask port).
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000,
   parameter int unsigned BLINK_FRAMES = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        active,
   input  logic [19:0] seg_data,
`ifdef SEGDISP_BLINK_EN
   input  logic [3:0]  blink_mask,
`endif
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [19:0] SHADOW_RST = 20'h7BDEF;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   localparam disp_t DISP_BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

   typedef enum logic {PH_BLANK, PH_DRIVE} phase_e;

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       d, d_nxt;
   logic [19:0]      shadow, shadow_nxt;
   disp_t            disp_q, disp_nxt;
   logic [31:0]      cnt_ext;
   logic             cnt_wrap;
   logic [4:0]       cur_code;
   logic             digit_off;
   phase_e           phase_c;

`ifdef SEGDISP_BLINK_EN
   localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FR_W-1:0] frame_cnt, frame_cnt_nxt;
   logic            blink_on, blink_on_nxt;
   logic [31:0]     frame_ext;
   assign frame_ext = 32'(frame_cnt);
`endif

   // Active-low glyph table for the low nibble of a code.
   function automatic logic [6:0] glyph(input logic [3:0] c);
      logic [6:0] g;
      case (c)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h2B;
         4'hB: g = 7'h03;
         4'hC: g = 7'h21;
         4'hD: g = 7'h41;
         4'hE: g = 7'h0C;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   assign cnt_ext  = 32'(cnt);
   assign cnt_wrap = (cnt_ext == REFRESH_DIV - 32'd1);
   assign phase_c  = (cnt_ext + 32'd1 <= BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;

   always_comb begin
      cur_code = shadow[4:0];
      case (d)
         2'd0: cur_code = shadow[4:0];
         2'd1: cur_code = shadow[9:5];
         2'd2: cur_code = shadow[14:10];
         2'd3: cur_code = shadow[19:15];
         default: cur_code = shadow[4:0];
      endcase
   end

`ifdef SEGDISP_BLINK_EN
   assign digit_off = !blink_on && blink_mask[d];
`else
   assign digit_off = 1'b0;
`endif

   // Next-state and next-output logic; inactive display holds the scan at frame start.
   always_comb begin
      cnt_nxt    = cnt;
      d_nxt      = d;
      shadow_nxt = shadow;
      disp_nxt   = DISP_BLANK;
`ifdef SEGDISP_BLINK_EN
      frame_cnt_nxt = frame_cnt;
      blink_on_nxt  = blink_on;
`endif
      if (!active) begin
         cnt_nxt    = '0;
         d_nxt      = '0;
         shadow_nxt = seg_data;
`ifdef SEGDISP_BLINK_EN
         frame_cnt_nxt = '0;
         blink_on_nxt  = 1'b1;
`endif
      end else begin
         if (cnt_wrap) begin
            cnt_nxt = '0;
            d_nxt   = d + 2'd1;
            if (d == 2'd3) begin
               shadow_nxt = seg_data;
`ifdef SEGDISP_BLINK_EN
               if (frame_ext == BLINK_FRAMES - 32'd1) begin
                  frame_cnt_nxt = '0;
                  blink_on_nxt  = !blink_on;
               end else begin
                  frame_cnt_nxt = frame_cnt + FR_W'(1);
               end
`endif
            end
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
         if (phase_c == PH_DRIVE && !digit_off) begin
            disp_nxt.an  = ~(4'b0001 << d);
            disp_nxt.seg = glyph(cur_code[3:0]);
            disp_nxt.dp  = !(cur_code[4] && (cur_code[3:0] != 4'hF));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         d      <= '0;
         shadow <= SHADOW_RST;
         disp_q <= DISP_BLANK;
`ifdef SEGDISP_BLINK_EN
         frame_cnt <= '0;
         blink_on  <= 1'b1;
`endif
      end else begin
         cnt    <= cnt_nxt;
         d      <= d_nxt;
         shadow <= shadow_nxt;
         disp_q <= disp_nxt;
`ifdef SEGDISP_BLINK_EN
         frame_cnt <= frame_cnt_nxt;
         blink_on  <= blink_on_nxt;
`endif
      end
   end

   assign an  = disp_q.an;
   assign seg = disp_q.seg;
   assign dp  = disp_q.dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with an 8-cycle slot and 2-cycle blank.
// With SEGDISP_BLINK_EN defined it also exercises per-digit blinking.
module tb_seg7_scan_driver;

   logic        clk;
   logic        reset;
   logic        active;
   logic [19:0] seg_data;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
`ifdef SEGDISP_BLINK_EN
   logic [3:0]  blink_mask;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [11:0] BL   = 12'hFFF;
   localparam logic [19:0] D16UP = {5'h01, 5'h06, 5'h0D, 5'h0E};
   localparam logic [19:0] DNEW  = {5'h1A, 5'h00, 5'h1F, 5'h17};

   seg7_scan_driver #(
      .REFRESH_DIV (8),
      .BLANK_CYCLES(2),
      .BLINK_FRAMES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .active    (active),
      .seg_data  (seg_data),
`ifdef SEGDISP_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // One clock; compare {an,seg,dp} and the single-anode rule.
   task automatic step(input string tag, input logic [11:0] exp);
      @(posedge clk);
      #1;
      chk(tag, 32'({an, seg, dp}), 32'(exp));
      chk({tag, "_onehot"}, 32'($countones(~an) <= 1), 32'd1);
   endtask

   task automatic slot(input string tag, input logic [3:0] a, input logic [6:0] s, input logic p);
      for (int i = 0; i < 8; i++) begin
         if (i < 2) step(tag, BL);
         else       step(tag, {a, s, p});
      end
   endtask

   initial begin
      reset    = 1'b1;
      active   = 1'b0;
      seg_data = 20'h7BDEF;
`ifdef SEGDISP_BLINK_EN
      blink_mask = 4'b0000;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset", 32'({an, seg, dp}), 32'(BL));

      // Blank shadow after reset; then load "16UP" for the next frame.
      reset  = 1'b0;
      active = 1'b1;
      slot("f0_d0", 4'hE, 7'h7F, 1'b1);
      seg_data = D16UP;
      slot("f0_d1", 4'hD, 7'h7F, 1'b1);
      slot("f0_d2", 4'hB, 7'h7F, 1'b1);
      slot("f0_d3", 4'h7, 7'h7F, 1'b1);
      slot("f1_d0", 4'hE, 7'h0C, 1'b1);
      slot("f1_d1", 4'hD, 7'h41, 1'b1);
      slot("f1_d2", 4'hB, 7'h02, 1'b1);
      slot("f1_d3", 4'h7, 7'h79, 1'b1);

      // Mid-frame update during digit 1: current frame keeps old glyphs.
      slot("f2_d0", 4'hE, 7'h0C, 1'b1);
      step("f2_d1", BL);
      step("f2_d1", BL);
      step("f2_d1", {4'hD, 7'h41, 1'b1});
      seg_data = DNEW;
      for (int i = 0; i < 5; i++) step("f2_d1", {4'hD, 7'h41, 1'b1});
      slot("f2_d2", 4'hB, 7'h02, 1'b1);
      slot("f2_d3", 4'h7, 7'h79, 1'b1);
      slot("f3_d0", 4'hE, 7'h78, 1'b0);
      slot("f3_d1", 4'hD, 7'h7F, 1'b1);
      slot("f3_d2", 4'hB, 7'h40, 1'b1);
      slot("f3_d3", 4'h7, 7'h2B, 1'b0);

      // Drop active mid-slot at digit 2; restart at digit 0 with the last inactive capture.
      slot("f4_d0", 4'hE, 7'h78, 1'b0);
      slot("f4_d1", 4'hD, 7'h7F, 1'b1);
      step("f4_d2", BL);
      step("f4_d2", BL);
      step("f4_d2", {4'hB, 7'h40, 1'b1});
      step("f4_d2", {4'hB, 7'h40, 1'b1});
      active = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) seg_data = D16UP;
         step("inactive", BL);
      end
      active = 1'b1;
      slot("re_d0", 4'hE, 7'h0C, 1'b1);
      slot("re_d1", 4'hD, 7'h41, 1'b1);

      // Reset mid-slot with active held high: reset wins and shadow returns to blank.
      step("re_d2", BL);
      step("re_d2", BL);
      step("re_d2", {4'hB, 7'h02, 1'b1});
      reset = 1'b1;
      step("mid_reset", BL);
      reset = 1'b0;
      slot("rr_d0", 4'hE, 7'h7F, 1'b1);
      slot("rr_d1", 4'hD, 7'h7F, 1'b1);

`ifdef SEGDISP_BLINK_EN
      begin
         logic [5:0] lit;
         lit = 6'b110011;
         reset = 1'b1;
         step("bl_reset", BL);
         reset      = 1'b0;
         active     = 1'b0;
         seg_data   = D16UP;
         blink_mask = 4'b0001;
         step("bl_idle", BL);
         active = 1'b1;
         for (int f = 0; f < 6; f++) begin
            if (lit[f]) slot("bl_d0", 4'hE, 7'h0C, 1'b1);
            else        slot("bl_d0_off", 4'hF, 7'h7F, 1'b1);
            slot("bl_d1", 4'hD, 7'h41, 1'b1);
            slot("bl_d2", 4'hB, 7'h02, 1'b1);
            slot("bl_d3", 4'h7, 7'h79, 1'b1);
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
